// File: rtl/cache_line_fill_ctrl_if.sv
// Fill-controller bus bundle: fetch handshake, dirty/valid-bit array strobes,
// external byte-read channel and cache RAM write port.
interface cache_line_fill_ctrl_if #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_BYTES = 8,
  parameter int unsigned ADDR_W     = 16
);
  localparam int unsigned OFF_W = $clog2(LINES * LINE_BYTES);

  logic              fetch_req;
  logic [OFF_W-1:0]  fetch_addr;
  logic [ADDR_W-1:0] line_base;
  logic              cache_flush;
  logic [LINES-1:0]  dirty_bits;
  logic              line_set;
  logic [LINES-1:0]  line_sel;
  logic              line_clr;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              cache_we;
  logic [OFF_W-1:0]  cache_waddr;
  logic [7:0]        cache_wdata;
  logic              fill_busy;
  logic              fetch_done;

  // Controller side
  modport master (
    input  fetch_req, fetch_addr, line_base, cache_flush, dirty_bits,
           mem_ack, mem_rdata,
    output line_set, line_sel, line_clr, mem_rd_req, mem_addr,
           cache_we, cache_waddr, cache_wdata, fill_busy, fetch_done
  );

  // Requester / memory / bit-array side
  modport slave (
    output fetch_req, fetch_addr, line_base, cache_flush, dirty_bits,
           mem_ack, mem_rdata,
    input  line_set, line_sel, line_clr, mem_rd_req, mem_addr,
           cache_we, cache_waddr, cache_wdata, fill_busy, fetch_done
  );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Code-cache line fill sequencer: on a miss reads the 8 bytes of a line from
// external memory into cache RAM, then marks the line valid in the bit array.
module cache_line_fill_ctrl #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_BYTES = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input logic                   clk,
  input logic                   clr_n,
  cache_line_fill_ctrl_if.master bus
);
  localparam int unsigned LINE_W = $clog2(LINES);
  localparam int unsigned BYTE_W = $clog2(LINE_BYTES);
  localparam int unsigned OFF_W  = LINE_W + BYTE_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    REQ    = 3'd2,
    WRITE  = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        data_q, data_d;

  logic              mem_rd_req_q, mem_rd_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              cache_we_q, cache_we_d;
  logic [OFF_W-1:0]  cache_waddr_q, cache_waddr_d;
  logic [7:0]        cache_wdata_q, cache_wdata_d;
  logic              line_set_q, line_set_d;
  logic [LINES-1:0]  line_sel_q, line_sel_d;
  logic              line_clr_q, line_clr_d;
  logic              fetch_done_q, fetch_done_d;
  logic              fill_busy_q, fill_busy_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= IDLE;
      line_q        <= '0;
      byte_q        <= '0;
      base_q        <= '0;
      data_q        <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_addr_q    <= '0;
      cache_we_q    <= 1'b0;
      cache_waddr_q <= '0;
      cache_wdata_q <= '0;
      line_set_q    <= 1'b0;
      line_sel_q    <= '0;
      line_clr_q    <= 1'b0;
      fetch_done_q  <= 1'b0;
      fill_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      byte_q        <= byte_d;
      base_q        <= base_d;
      data_q        <= data_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_addr_q    <= mem_addr_d;
      cache_we_q    <= cache_we_d;
      cache_waddr_q <= cache_waddr_d;
      cache_wdata_q <= cache_wdata_d;
      line_set_q    <= line_set_d;
      line_sel_q    <= line_sel_d;
      line_clr_q    <= line_clr_d;
      fetch_done_q  <= fetch_done_d;
      fill_busy_q   <= fill_busy_d;
    end
  end

  // Next state, then outputs decoded from the next state so they register
  // in step with it
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    byte_d        = byte_q;
    base_d        = base_q;
    data_d        = data_q;
    mem_rd_req_d  = 1'b0;
    mem_addr_d    = '0;
    cache_we_d    = 1'b0;
    cache_waddr_d = '0;
    cache_wdata_d = '0;
    line_set_d    = 1'b0;
    line_sel_d    = '0;
    line_clr_d    = bus.cache_flush;
    fetch_done_d  = 1'b0;
    fill_busy_d   = 1'b0;

    if (bus.cache_flush) begin
      // Abort anything in flight; a late mem_ack then lands in IDLE and is ignored
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.fetch_req) begin
            line_d  = bus.fetch_addr[OFF_W-1:BYTE_W];
            base_d  = bus.line_base;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (bus.dirty_bits[line_q]) begin
            state_d = DONE;
          end else begin
            byte_d  = '0;
            state_d = REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            data_d  = bus.mem_rdata;
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (byte_q == BYTE_W'(LINE_BYTES - 1)) begin
            state_d = COMMIT;
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            state_d = REQ;
          end
        end
        COMMIT:  state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    fill_busy_d = (state_d != IDLE);
    case (state_d)
      REQ: begin
        mem_rd_req_d = 1'b1;
        mem_addr_d   = base_d + ADDR_W'({line_d, byte_d});
      end
      WRITE: begin
        cache_we_d    = 1'b1;
        cache_waddr_d = {line_d, byte_d};
        cache_wdata_d = data_d;
      end
      COMMIT: begin
        line_set_d = 1'b1;
        line_sel_d = LINES'(1) << line_d;
      end
      DONE:    fetch_done_d = 1'b1;
      default: ;
    endcase
  end

  // The bit array must also see a clear for the whole time reset is held
  assign bus.line_clr    = line_clr_q | ~clr_n;
  assign bus.line_set    = line_set_q;
  assign bus.line_sel    = line_sel_q;
  assign bus.mem_rd_req  = mem_rd_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.cache_we    = cache_we_q;
  assign bus.cache_waddr = cache_waddr_q;
  assign bus.cache_wdata = cache_wdata_q;
  assign bus.fill_busy   = fill_busy_q;
  assign bus.fetch_done  = fetch_done_q;

endmodule
